// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM states and flag bundle.
package alu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00001;
  localparam logic [4:0] OP_MI   = 5'b00010;
  localparam logic [4:0] OP_MR   = 5'b00011;
  localparam logic [4:0] OP_SUM  = 5'b00100;
  localparam logic [4:0] OP_SB   = 5'b00101;
  localparam logic [4:0] OP_AN   = 5'b00110;
  localparam logic [4:0] OP_CM   = 5'b00111;
  localparam logic [4:0] OP_OR   = 5'b01000;
  localparam logic [4:0] OP_ORR  = 5'b01001;
  localparam logic [4:0] OP_XR   = 5'b01010;
  localparam logic [4:0] OP_XRR  = 5'b01011;
  localparam logic [4:0] OP_SUMR = 5'b01100;
  localparam logic [4:0] OP_SBR  = 5'b01101;
  localparam logic [4:0] OP_ANR  = 5'b01110;
  localparam logic [4:0] OP_CMR  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_DIV  = 5'b10001;
  localparam logic [4:0] OP_SHL  = 5'b10010;
  localparam logic [4:0] OP_SHR  = 5'b10011;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    ITER = 2'b10,
    DONE = 2'b11
  } alu_state_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic neg;
    logic ovf;
    logic div_zero;
    logic illegal;
  } alu_flags_t;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the pipeline and the sequential ALU.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             carry;
  logic             neg;
  logic             ovf;
  logic             div_zero;
  logic             illegal;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, result_hi,
    input  zero, carry, neg, ovf, div_zero, illegal
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, result_hi,
    output zero, carry, neg, ovf, div_zero, illegal
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle unsigned shift-add multiplier and restoring divider.
// res_o is {high, low} for multiply and {remainder, quotient} for divide.
module alu_muldiv_iter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               mode_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] res_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             busy_q;
  logic             done_q;
  logic             mode_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   macc_s;
  logic [WIDTH:0]   rsh_s;
  logic [WIDTH:0]   rsub_s;

  assign add_s  = {1'b0, hi_q} + {1'b0, opnd_q};
  assign macc_s = lo_q[0] ? add_s : {1'b0, hi_q};
  // Divider: partial remainder shifted left with the next dividend bit; negative trial means restore.
  assign rsh_s  = {hi_q, lo_q[WIDTH-1]};
  assign rsub_s = rsh_s - {1'b0, opnd_q};

  // Operand load on start, then one iteration per cycle while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      mode_q <= 1'b0;
      cnt_q  <= {CW{1'b0}};
      opnd_q <= {WIDTH{1'b0}};
      hi_q   <= {WIDTH{1'b0}};
      lo_q   <= {WIDTH{1'b0}};
    end else if (start_i) begin
      busy_q <= 1'b1;
      done_q <= 1'b0;
      mode_q <= mode_i;
      cnt_q  <= CW'(WIDTH);
      opnd_q <= mode_i ? b_i : a_i;
      hi_q   <= {WIDTH{1'b0}};
      lo_q   <= mode_i ? a_i : b_i;
    end else if (busy_q) begin
      cnt_q  <= cnt_q - CW'(1);
      done_q <= (cnt_q == CW'(1));
      busy_q <= (cnt_q != CW'(1));
      if (mode_q) begin
        hi_q <= rsub_s[WIDTH] ? rsh_s[WIDTH-1:0] : rsub_s[WIDTH-1:0];
        lo_q <= {lo_q[WIDTH-2:0], ~rsub_s[WIDTH]};
      end else begin
        hi_q <= macc_s[WIDTH:1];
        lo_q <= {macc_s[0], lo_q[WIDTH-1:1]};
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done_o = done_q;
  assign res_o  = {hi_q, lo_q};

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: legacy single-cycle ops plus iterative MUL/DIV and shifts.
// Results and flags are registered and held until the consumer takes them.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MULDIV_EN = 1'b1
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [4:0]       op_q;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  alu_flags_t       flags_q, flags_d;

  logic               accept_s;
  logic               iter_start_s;
  logic               md_done_s;
  logic [2*WIDTH-1:0] md_res_s;

  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     dif_s;
  logic [2*WIDTH-1:0] shl_s;
  logic [2*WIDTH-1:0] shr_s;
  logic [WIDTH-1:0]   exec_res_s;
  logic [WIDTH-1:0]   exec_hi_s;
  alu_flags_t         exec_flags_s;

  assign accept_s = bus.in_valid && (state_q == IDLE);
  // Divide by zero is resolved on the single-cycle path and never enters the iterator.
  assign iter_start_s = accept_s && MULDIV_EN && is_muldiv(bus.op) &&
                        !((bus.op == OP_DIV) && (bus.b == {WIDTH{1'b0}}));

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (iter_start_s),
    .mode_i  (bus.op == OP_DIV),
    .a_i     (bus.a),
    .b_i     (bus.b),
    .done_o  (md_done_s),
    .res_o   (md_res_s)
  );

  assign sum_s = {1'b0, a_q} + {1'b0, b_q};
  assign dif_s = {1'b0, a_q} - {1'b0, b_q};
  assign shl_s = {{WIDTH{1'b0}}, a_q} << b_q[SHW-1:0];
  assign shr_s = {a_q, {WIDTH{1'b0}}} >> b_q[SHW-1:0];

  // Single-cycle datapath evaluated on the captured operands.
  always_comb begin
    exec_res_s   = {WIDTH{1'b0}};
    exec_hi_s    = {WIDTH{1'b0}};
    exec_flags_s = '0;
    case (op_q)
      OP_LD, OP_ST:   exec_res_s = a_q;
      OP_MI, OP_MR:   exec_res_s = b_q;
      OP_SUM, OP_SUMR: begin
        exec_res_s         = sum_s[WIDTH-1:0];
        exec_flags_s.carry = sum_s[WIDTH];
        exec_flags_s.ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_s[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SB, OP_SBR: begin
        exec_res_s         = dif_s[WIDTH-1:0];
        exec_flags_s.carry = dif_s[WIDTH];
        exec_flags_s.ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif_s[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_CM, OP_CMR: begin
        exec_res_s         = {{(WIDTH-1){1'b0}}, dif_s[WIDTH]};
        exec_flags_s.carry = dif_s[WIDTH];
      end
      OP_AN, OP_ANR:  exec_res_s = a_q & b_q;
      OP_OR, OP_ORR:  exec_res_s = a_q | b_q;
      OP_XR, OP_XRR:  exec_res_s = a_q ^ b_q;
      OP_SHL: begin
        exec_res_s         = shl_s[WIDTH-1:0];
        exec_flags_s.carry = shl_s[WIDTH];
      end
      OP_SHR: begin
        exec_res_s         = shr_s[2*WIDTH-1:WIDTH];
        exec_flags_s.carry = shr_s[WIDTH-1];
      end
      OP_DIV: begin
        if (MULDIV_EN) begin
          exec_res_s            = {WIDTH{1'b1}};
          exec_hi_s             = a_q;
          exec_flags_s.div_zero = 1'b1;
        end else begin
          exec_flags_s.illegal = 1'b1;
        end
      end
      OP_MUL:  exec_flags_s.illegal = 1'b1;
      default: exec_flags_s.illegal = 1'b1;
    endcase
    exec_flags_s.zero = (exec_res_s == {WIDTH{1'b0}});
    exec_flags_s.neg  = exec_res_s[WIDTH-1];
  end

  // Next state and next value of the result/flag registers.
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          flags_d = '0;
          state_d = iter_start_s ? ITER : EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        state_d  = DONE;
        res_d    = exec_res_s;
        res_hi_d = exec_hi_s;
        flags_d  = exec_flags_s;
      end
      ITER: begin
        if (md_done_s) begin
          state_d       = DONE;
          res_d         = md_res_s[WIDTH-1:0];
          res_hi_d      = md_res_s[2*WIDTH-1:WIDTH];
          flags_d       = '0;
          flags_d.zero  = (md_res_s[WIDTH-1:0] == {WIDTH{1'b0}});
          flags_d.neg   = md_res_s[WIDTH-1];
        end else begin
          state_d = ITER;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand capture and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      op_q     <= 5'b00000;
      res_q    <= {WIDTH{1'b0}};
      res_hi_q <= {WIDTH{1'b0}};
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      flags_q  <= flags_d;
      if (accept_s) begin
        a_q  <= bus.a;
        b_q  <= bus.b;
        op_q <= bus.op;
      end else begin
        a_q  <= a_q;
        b_q  <= b_q;
        op_q <= op_q;
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.result_hi = res_hi_q;
  assign bus.zero      = flags_q.zero;
  assign bus.carry     = flags_q.carry;
  assign bus.neg       = flags_q.neg;
  assign bus.ovf       = flags_q.ovf;
  assign bus.div_zero  = flags_q.div_zero;
  assign bus.illegal   = flags_q.illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed cases plus randomized ops
// compared against an arithmetic reference model.
module tb_alu_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8), .MULDIV_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [5:0] dut_flags;
  assign dut_flags = {bus.zero, bus.carry, bus.neg, bus.ovf, bus.div_zero, bus.illegal};

  always #5 clk = ~clk;

  // Flags packed as {zero, carry, neg, ovf, div_zero, illegal}.
  function automatic void model(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] r, output logic [7:0] h, output logic [5:0] f);
    int ua, ub, sa, sb, t, sh;
    logic c, v, dz, il;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    t = 0; sh = 0; c = 1'b0; v = 1'b0; dz = 1'b0; il = 1'b0; h = 8'h00;
    if (!op[4]) begin
      case (op[3:0])
        4'd0, 4'd1:   t = ua;
        4'd2, 4'd3:   t = ub;
        4'd4, 4'd12: begin t = ua + ub; c = (t > 255); v = (sa + sb > 127) || (sa + sb < -128); end
        4'd5, 4'd13: begin t = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
        4'd7, 4'd15: begin t = (ua < ub) ? 1 : 0; c = (ua < ub); end
        4'd6, 4'd14:  t = ua & ub;
        4'd8, 4'd9:   t = ua | ub;
        default:      t = ua ^ ub;
      endcase
    end else begin
      case (op[3:0])
        4'd0: begin t = ua * ub; h = 8'(t / 256); end
        4'd1: begin
          if (ub == 0) begin t = 255; h = a; dz = 1'b1; end
          else begin t = ua / ub; h = 8'(ua % ub); end
        end
        4'd2: begin sh = ub % 8; t = ua << sh; c = ((t >> 8) & 1) == 1; end
        4'd3: begin sh = ub % 8; t = ua >> sh; c = (sh != 0) && (((ua >> (sh - 1)) & 1) == 1); end
        default: begin t = 0; il = 1'b1; end
      endcase
    end
    r = 8'(t);
    f = {(r == 8'h00), c, r[7], v, dz, il};
  endfunction

  // Presents an op and returns just after the edge that accepted it; operands are then scrambled.
  task automatic send_op(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout in_ready=%b after %0d cycles", bus.in_ready, n);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op = 5'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
  endtask

  // Latency counts the accepting edge as 1; caps at 40 if out_valid never appears.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.result !== 8'h00 || bus.result_hi !== 8'h00) begin
      bad++; $display("FAIL rst_result got=%h/%h want=00/00", bus.result, bus.result_hi); end
    total++; if (dut_flags !== 6'b000000) begin bad++; $display("FAIL rst_flags got=%b want=000000", dut_flags); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", bus.in_ready); end
  endtask

  task automatic test_add_sub();
    int lat;
    send_op(5'b00100, 8'hF0, 8'h20); wait_result(lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL sum_latency got=%0d want=2", lat); end
    total++; if (bus.result !== 8'h10) begin bad++; $display("FAIL sum_result got=%h want=10", bus.result); end
    total++; if (dut_flags !== 6'b010000) begin bad++; $display("FAIL sum_flags got=%b want=010000", dut_flags); end
    consume();
    send_op(5'b00101, 8'h03, 8'h05); wait_result(lat);
    total++; if (bus.result !== 8'hFE || dut_flags !== 6'b011000) begin
      bad++; $display("FAIL sb_borrow got=%h/%b want=fe/011000", bus.result, dut_flags); end
    consume();
    send_op(5'b00101, 8'h80, 8'h01); wait_result(lat);
    total++; if (bus.result !== 8'h7F || dut_flags !== 6'b000100) begin
      bad++; $display("FAIL sb_ovf got=%h/%b want=7f/000100", bus.result, dut_flags); end
    consume();
    send_op(5'b00111, 8'h05, 8'h05); wait_result(lat);
    total++; if (bus.result !== 8'h00 || dut_flags !== 6'b100000) begin
      bad++; $display("FAIL cm_equal got=%h/%b want=00/100000", bus.result, dut_flags); end
    consume();
  endtask

  task automatic test_mul();
    int lat;
    logic rdy_seen;
    rdy_seen = 1'b0;
    send_op(5'b10000, 8'hFF, 8'hFF);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1; lat++;
    end
    total++; if (lat !== 10) begin bad++; $display("FAIL mul_latency got=%0d want=10", lat); end
    total++; if (rdy_seen !== 1'b0 || bus.in_ready !== 1'b0) begin
      bad++; $display("FAIL mul_in_ready got=%b want=0 during op", rdy_seen | bus.in_ready); end
    total++; if (bus.result !== 8'h01 || bus.result_hi !== 8'hFE) begin
      bad++; $display("FAIL mul_result got=%h:%h want=fe:01", bus.result_hi, bus.result); end
    consume();
  endtask

  task automatic test_div();
    int lat;
    send_op(5'b10001, 8'd100, 8'd7); wait_result(lat);
    total++; if (bus.result !== 8'd14 || bus.result_hi !== 8'd2 || lat !== 10) begin
      bad++; $display("FAIL div_result got=q%0d r%0d lat%0d want=q14 r2 lat10", bus.result, bus.result_hi, lat); end
    consume();
    send_op(5'b10001, 8'h33, 8'h00); wait_result(lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL divzero_latency got=%0d want=2", lat); end
    total++; if (bus.result !== 8'hFF || bus.result_hi !== 8'h33 || dut_flags !== 6'b001010) begin
      bad++; $display("FAIL divzero_result got=%h/%h/%b want=ff/33/001010", bus.result, bus.result_hi, dut_flags); end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [7:0] xa, xb, er, eh;
    logic [5:0] ef;
    xa = 8'($urandom); xb = 8'($urandom);
    model(5'b01011, xa, xb, er, eh, ef);
    send_op(5'b01011, xa, xb); wait_result(lat);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.op = 5'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
      @(posedge clk); #1;
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== er ||
          bus.result_hi !== eh || dut_flags !== ef) begin
        bad++;
        $display("FAIL hold_%0d got=v%b r%b %h/%h/%b want=v1 r0 %h/%h/%b", i, bus.out_valid,
                 bus.in_ready, bus.result, bus.result_hi, dut_flags, er, eh, ef);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL ready_same_cycle got=%b want=0", bus.in_ready); end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL ready_after_consume got=r%b v%b want=r1 v0", bus.in_ready, bus.out_valid); end
    send_op(5'b10111, 8'h5A, 8'hA5); wait_result(lat);
    total++; if (bus.result !== 8'h00 || dut_flags !== 6'b100001 || lat !== 2) begin
      bad++; $display("FAIL illegal_op got=%h/%b lat%0d want=00/100001 lat2", bus.result, dut_flags, lat); end
    consume();
  endtask

  task automatic test_reset_mid_op();
    int lat;
    send_op(5'b00100, 8'h12, 8'h34); wait_result(lat);
    consume();
    send_op(5'b10000, 8'hC3, 8'h7E);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.result !== 8'h00 || bus.result_hi !== 8'h00 || dut_flags !== 6'b000000) begin
      bad++; $display("FAIL reset_mid_mul got=v%b %h/%h/%b want=v0 00/00/000000", bus.out_valid,
                      bus.result, bus.result_hi, dut_flags); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++; $display("FAIL after_reset got=r%b v%b want=r1 v0", bus.in_ready, bus.out_valid); end
    send_op(5'b10010, 8'h81, 8'h01); wait_result(lat);
    total++; if (bus.result !== 8'h02 || dut_flags !== 6'b010000) begin
      bad++; $display("FAIL shl_carry got=%h/%b want=02/010000", bus.result, dut_flags); end
    consume();
  endtask

  task automatic test_random();
    int lat, elat, hold;
    logic [4:0] op;
    logic [7:0] a, b, er, eh;
    logic [5:0] ef;
    for (int n = 0; n < 40; n++) begin
      op = 5'($urandom_range(0, 31));
      a  = 8'($urandom); b = 8'($urandom);
      if (op == 5'b10001 && $urandom_range(0, 3) == 0) b = 8'h00;
      model(op, a, b, er, eh, ef);
      elat = ((op == 5'b10000) || (op == 5'b10001 && b != 8'h00)) ? 10 : 2;
      send_op(op, a, b); wait_result(lat);
      hold = $urandom_range(0, 2);
      repeat (hold) begin @(posedge clk); #1; end
      total++;
      if (lat !== elat || bus.out_valid !== 1'b1 || bus.result !== er || bus.result_hi !== eh || dut_flags !== ef) begin
        bad++;
        $display("FAIL rand_%0d op=%b a=%h b=%h got=%h/%h/%b lat%0d want=%h/%h/%b lat%0d", n, op, a, b,
                 bus.result, bus.result_hi, dut_flags, lat, er, eh, ef, elat);
      end
      consume();
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.op        = 5'b00000;
    test_reset();
    test_add_sub();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
